decode_ctrl_stage: RTL

Registered, handshaked successor to the combinational RV32I control decoder. Decodes OPCODE/FUNC3/FUNC7 into the datapath control bundle, holds it in an ID/EX output register with valid/ready flow control, and adds RV32M support: MUL*/DIV*/REM* are held for a parametrised number of cycles, with issue stalled, before their bundle is released. It sits between the instruction fetch/decode register and the execute stage.

---
 rtl/decode_ctrl_stage.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//
// Registered RV32I control decoder with valid/ready flow control. It decodes
// opcode/func3/func7 into the datapath control bundle and holds that bundle in an
// ID/EX output register. With DECODE_M_EXT_EN defined, it also decodes RV32M
// (MUL*/DIV*/REM*). An M instruction holds issue for MUL_CYCLES or DIV_CYCLES
// cycles before its bundle is released. When the macro is undefined, M encodings
// decode as illegal.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready        instruction handshake (in_ready is combinational
//                              on out_ready and flush)
//   opcode, func3, func7       instruction fields
//   flush                      discards the held or in-progress instruction
//   out_valid / out_ready      bundle handshake toward execute
//   reg_write_en .. alu_op     registered control bundle
//   illegal                    registered: the held opcode is unrecognised
//   busy                       multi-cycle M operation in progress

module decode_ctrl_stage #(
    parameter int unsigned ALU_OP_W   = 5,
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          func3,
    input  logic [6:0]          func7,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                reg_write_en,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic                comp_sel,
    output logic                op1_sel,
    output logic                op2_sel,
    output logic [1:0]          wb_value_sel,
    output logic [1:0]          bj_ctrl,
    output logic [2:0]          imm_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                busy
);

    if (ALU_OP_W < 5 || MUL_CYCLES < 1 || MUL_CYCLES > 15 ||
        DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cfg
        $error("decode_ctrl_stage: parameter out of range");
    end

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] F7MulDiv = 7'b0000001;

    typedef struct packed {
        logic                illegal;
        logic                reg_write_en;
        logic                mem_read_en;
        logic                mem_write_en;
        logic                comp_sel;
        logic                op1_sel;
        logic                op2_sel;
        logic [1:0]          wb_value_sel;
        logic [1:0]          bj_ctrl;
        logic [2:0]          imm_sel;
        logic [ALU_OP_W-1:0] alu_op;
    } bundle_t;

    bundle_t    dec;
    bundle_t    bundle_q;
    logic [4:0] alu5;
    logic       accept;
    logic       load;
    logic       out_valid_q;
    logic       out_valid_d;
`ifdef DECODE_M_EXT_EN
    logic       dec_m;
    logic       dec_div;
`endif

    // Combinational decode of the incoming fields; only ever seen through bundle_q.
    always_comb begin
        dec  = '0;
        alu5 = 5'b00000;
`ifdef DECODE_M_EXT_EN
        dec_m   = 1'b0;
        dec_div = 1'b0;
`endif
        case (opcode)
            OpLui: begin
                dec.reg_write_en = 1'b1;
                alu5             = 5'b10000;
            end
            OpAuipc: begin
                dec.reg_write_en = 1'b1;
                dec.op1_sel      = 1'b1;
                dec.op2_sel      = 1'b1;
                dec.imm_sel      = 3'd3;
            end
            OpJal: begin
                dec.reg_write_en = 1'b1;
                dec.bj_ctrl      = 2'b01;
                dec.wb_value_sel = 2'd2;
                dec.op1_sel      = 1'b1;
                dec.op2_sel      = 1'b1;
                dec.imm_sel      = 3'd1;
            end
            OpJalr: begin
                dec.reg_write_en = 1'b1;
                dec.bj_ctrl      = 2'b01;
                dec.wb_value_sel = 2'd2;
                dec.op2_sel      = 1'b1;
                dec.imm_sel      = 3'd4;
            end
            OpBranch: begin
                dec.bj_ctrl  = 2'b10;
                dec.comp_sel = 1'b1;
            end
            OpLoad: begin
                dec.mem_read_en  = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.wb_value_sel = 2'd1;
                dec.op2_sel      = 1'b1;
                dec.imm_sel      = 3'd4;
            end
            OpStore: begin
                dec.mem_write_en = 1'b1;
                dec.op2_sel      = 1'b1;
                dec.imm_sel      = 3'd2;
            end
            OpImm: begin
                dec.reg_write_en = 1'b1;
                dec.op2_sel      = 1'b1;
                dec.imm_sel      = 3'd4;
                // Only SRAI carries the func7[5] arithmetic bit for immediates.
                alu5 = {1'b0, (func3 == 3'b101) & func7[5], func3};
            end
            OpReg: begin
                if (func7 == F7MulDiv) begin
`ifdef DECODE_M_EXT_EN
                    dec.reg_write_en = 1'b1;
                    alu5             = {2'b01, func3};
                    dec_m            = 1'b1;
                    dec_div          = func3[2];
`else
                    dec.illegal = 1'b1;
`endif
                end else begin
                    dec.reg_write_en = 1'b1;
                    alu5             = {1'b0, func7[5], func3};
                    dec.comp_sel     = func7[5] & ~func3[0];
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.alu_op = ALU_OP_W'(alu5);
    end

    assign accept = in_valid & in_ready;

`ifdef DECODE_M_EXT_EN
    typedef enum logic [0:0] {StIdle, StWait} state_e;

    localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] lat_load;

    assign lat_load = dec_div ? DivLoad : MulLoad;
    assign in_ready = (state_q == StIdle) & ~flush & (~out_valid_q | out_ready);
    assign busy     = (state_q == StWait);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        if (flush) begin
            state_d     = StIdle;
            cnt_d       = 4'd0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        load = 1'b1;
                        // A latency of 1 has nothing to count, so it takes the plain path.
                        if (dec_m && lat_load != 4'd0) begin
                            out_valid_d = 1'b0;
                            state_d     = StWait;
                            cnt_d       = lat_load;
                        end else begin
                            out_valid_d = 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                StWait: begin
                    // Release on the edge where the counter reaches zero.
                    if (cnt_q <= 4'd1) begin
                        out_valid_d = 1'b1;
                        state_d     = StIdle;
                        cnt_d       = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign in_ready = ~flush & (~out_valid_q | out_ready);
    assign busy     = 1'b0;

    always_comb begin
        out_valid_d = out_valid_q;
        load        = accept;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Flush leaves bundle_q stale on purpose; it is masked by out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                bundle_q <= dec;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign illegal      = bundle_q.illegal;
    assign reg_write_en = bundle_q.reg_write_en;
    assign mem_read_en  = bundle_q.mem_read_en;
    assign mem_write_en = bundle_q.mem_write_en;
    assign comp_sel     = bundle_q.comp_sel;
    assign op1_sel      = bundle_q.op1_sel;
    assign op2_sel      = bundle_q.op2_sel;
    assign wb_value_sel = bundle_q.wb_value_sel;
    assign bj_ctrl      = bundle_q.bj_ctrl;
    assign imm_sel      = bundle_q.imm_sel;
    assign alu_op       = bundle_q.alu_op;

endmodule
